// File: rtl/rom_byte_streamer_if.sv
// Byte-stream handshake bundle between the ROM byte streamer and its sink.
// A byte transfers on a rising edge where tx_valid and tx_ready are both high.
interface rom_byte_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/rom_byte_streamer.sv
// Walks a bit-addressed ROM with a one-cycle registered read and packs the
// bits MSB-first into bytes, presented on a valid/ready byte stream.
// Each byte costs 9 FETCH cycles (8 issues plus one cycle of read latency)
// followed by at least one SEND cycle.
module rom_byte_streamer #(
  parameter int NBITS = 616,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic [AW-1:0]        rom_addr_o,
  input  logic                 rom_dout_i,
  rom_byte_streamer_if.master  tx,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int NBYTES = (NBITS + 7) / 8;
  // Bit positions run up to NBYTES*8-1, which can exceed the ROM range.
  localparam int PW = AW + 1;
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [PW-1:0] NBITS_P   = PW'(NBITS);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   rom_addr_q;
  logic [PW-1:0]   bitpos_q;    // bit position issued in the current cycle
  logic            iss_q;       // current FETCH cycle issues a bit
  logic [2:0]      iss_cnt_q;
  logic            dly_q;       // previous cycle issued: rom_dout is valid now
  logic            dly_pad_q;   // previous issue was a padding position
  logic [2:0]      cap_cnt_q;
  logic [7:0]      shift_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;
  logic            tx_last_q;
  logic            busy_q;
  logic            done_q;

  logic [PW-1:0]   bitpos_d;
  logic [7:0]      shift_d;
  logic            issue_pad_s;
  logic            next_in_range_s;
  logic            handshake_s;

  // Next-position, shift-in and padding helpers for the FETCH datapath.
  always_comb begin
    bitpos_d        = bitpos_q + PW'(1);
    issue_pad_s     = (bitpos_q >= NBITS_P);
    next_in_range_s = (bitpos_d < NBITS_P);
    handshake_s     = tx_valid_q & tx.tx_ready;
    if (dly_pad_q) begin
      shift_d = {shift_q[6:0], 1'b0};
    end else begin
      shift_d = {shift_q[6:0], rom_dout_i};
    end
  end

  // Frame FSM: issues ROM addresses, captures returned bits, drives the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      bitpos_q   <= '0;
      iss_q      <= 1'b0;
      iss_cnt_q  <= 3'd0;
      dly_q      <= 1'b0;
      dly_pad_q  <= 1'b0;
      cap_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      byte_cnt_q <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            bitpos_q   <= '0;
            rom_addr_q <= '0;
            iss_q      <= 1'b1;
            iss_cnt_q  <= 3'd0;
            dly_q      <= 1'b0;
            cap_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
          end
        end

        S_FETCH: begin
          dly_q     <= iss_q;
          dly_pad_q <= issue_pad_s;
          if (iss_q) begin
            bitpos_q  <= bitpos_d;
            iss_cnt_q <= iss_cnt_q + 3'd1;
            // Positions past the ROM are padding: the address is left alone
            // so it never leaves the ROM range.
            if (next_in_range_s) begin
              rom_addr_q <= bitpos_d[AW-1:0];
            end
            if (iss_cnt_q == 3'd7) begin
              iss_q <= 1'b0;
            end
          end
          if (dly_q) begin
            shift_q   <= shift_d;
            cap_cnt_q <= cap_cnt_q + 3'd1;
            if (cap_cnt_q == 3'd7) begin
              state_q    <= S_SEND;
              tx_valid_q <= 1'b1;
              tx_data_q  <= shift_d;
              tx_last_q  <= (byte_cnt_q == LAST_BYTE);
            end
          end
        end

        S_SEND: begin
          if (handshake_s) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            if (byte_cnt_q == LAST_BYTE) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              byte_cnt_q <= byte_cnt_q + BW'(1);
              iss_q      <= 1'b1;
              iss_cnt_q  <= 3'd0;
              dly_q      <= 1'b0;
              cap_cnt_q  <= 3'd0;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_last  = tx_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Scoreboard bench for rom_byte_streamer: a 616-bit instance and a 20-bit
// instance (padding case), each fed by a registered behavioural ROM.
module tb_rom_byte_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_start = 1'b0;
  logic [9:0] big_addr, s_addr;
  logic big_dout = 1'b0, s_dout = 1'b0;
  logic big_busy, big_done, s_busy, s_done;

  rom_byte_streamer_if big_if ();
  rom_byte_streamer_if s_if ();

  rom_byte_streamer #(.NBITS(616), .AW(10)) dut (
    .clk(clk), .rst(rst), .start_i(start), .rom_addr_o(big_addr),
    .rom_dout_i(big_dout), .tx(big_if), .busy_o(big_busy), .done_o(big_done)
  );

  rom_byte_streamer #(.NBITS(20), .AW(10)) dut_s (
    .clk(clk), .rst(rst), .start_i(s_start), .rom_addr_o(s_addr),
    .rom_dout_i(s_dout), .tx(s_if), .busy_o(s_busy), .done_o(s_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame contents of the big ROM, one byte per index.
  function automatic logic [7:0] rom_byte(input int k);
    int v;
    v = (k * 29 + 90) ^ (k >> 2);
    return v[7:0];
  endfunction

  function automatic logic rom_bit(input int a);
    logic [7:0] b;
    int i;
    b = rom_byte(a / 8);
    i = 7 - (a % 8);
    return b[i];
  endfunction

  // 20-bit ROM: bytes A5, 3C, then bits 16..19 = 4'hD; out of range reads 1.
  function automatic logic s_bit(input int a);
    logic [23:0] v;
    v = 24'hA53CD7;
    if (a < 20) return v[23 - a];
    else return 1'b1;
  endfunction

  // Registered ROM models: dout in cycle t+1 reflects the address of cycle t.
  always @(posedge clk) big_dout <= rom_bit(int'(big_addr));
  always @(posedge clk) s_dout <= s_bit(int'(s_addr));

  // tx_ready driver for the big instance.
  int rdy_mode = 0;
  initial big_if.tx_ready = 1'b1;
  initial s_if.tx_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) big_if.tx_ready = 1'b1;
    else big_if.tx_ready = ($urandom_range(0, 99) < 30);
  end

  // Scoreboards: {tx_last, tx_data}.
  logic [8:0] exp_q[$];
  logic [8:0] s_exp_q[$];

  int fv_cyc = -1, last_hs = -1, done_cyc = -1, done_cnt = 0, nbytes = 0;
  int max_addr = 0;
  int s_done_cnt = 0, s_nbytes = 0, s_max = 0;
  logic stall_prev = 1'b0;
  logic [19:0] prev_snap = 20'd0;

  // Monitor for the big instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {big_if.tx_valid, big_if.tx_last, big_if.tx_data, big_addr}, prev_snap);
      if (big_if.tx_valid && fv_cyc < 0) fv_cyc = cyc;
      if (int'(big_addr) > max_addr) max_addr = int'(big_addr);
      if (big_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (big_if.tx_valid && big_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h, want none", big_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", nbytes), {23'd0, big_if.tx_last, big_if.tx_data}, {23'd0, e});
        end
        nbytes++;
        last_hs = cyc + 1;
      end
      stall_prev = big_if.tx_valid && !big_if.tx_ready;
      prev_snap = {1'b1, big_if.tx_last, big_if.tx_data, big_addr};
    end
  end

  // Monitor for the 20-bit instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (int'(s_addr) > s_max) s_max = int'(s_addr);
      if (s_done) s_done_cnt++;
      if (s_if.tx_valid && s_if.tx_ready) begin
        if (s_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL small_unexpected: got 0x%0h, want none", s_if.tx_data);
        end else begin
          e = s_exp_q.pop_front();
          check($sformatf("small_byte%0d", s_nbytes), {23'd0, s_if.tx_last, s_if.tx_data}, {23'd0, e});
        end
        s_nbytes++;
      end
    end
  end

  int e_cyc = 0;

  task automatic start_frame();
    fv_cyc = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; nbytes = 0; max_addr = 0;
    for (int k = 0; k < 77; k++) exp_q.push_back({(k == 76), rom_byte(k)});
    @(posedge clk); #1;
    start = 1'b1;
    e_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done, want done within %0d cycles", budget);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_byte_count"}, nbytes, 77);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_max_addr"}, max_addr, 615);
    check({tag, "_idle_after"}, {big_busy, big_if.tx_valid}, 2'b00);
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {big_if.tx_valid, big_if.tx_last, big_busy, big_done, big_if.tx_data, big_addr},
          20'd0);
    rst = 1'b0;

    // Idle without start.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle", {big_if.tx_valid, big_busy, big_done, big_addr}, 13'd0);
    end

    // 20-bit ROM: third byte padded with zeros.
    s_exp_q.push_back({1'b0, 8'hA5});
    s_exp_q.push_back({1'b0, 8'h3C});
    s_exp_q.push_back({1'b1, 8'hD0});
    @(posedge clk); #1; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    n = 0;
    while (s_done_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("small_done_count", s_done_cnt, 1);
    check("small_byte_count", s_nbytes, 3);
    check("small_max_addr", s_max, 19);
    check("small_queue_left", s_exp_q.size(), 0);

    // Full frame, ready always high, with latency checks.
    rdy_mode = 0;
    start_frame();
    wait_done(2000);
    check("first_valid_cycle", fv_cyc - e_cyc, 9);
    check("last_handshake_edge", last_hs - e_cyc, 770);
    check("done_cycle", done_cyc - e_cyc, 770);
    end_checks("ready_high");

    // Full frame with pseudo-random back-pressure.
    rdy_mode = 1;
    start_frame();
    wait_done(6000);
    end_checks("random_ready");
    rdy_mode = 0;

    // start while busy is ignored.
    start_frame();
    n = 0;
    while (nbytes < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(2000);
    end_checks("start_busy");

    // Reset during the FETCH of byte 40.
    start_frame();
    n = 0;
    while (!(nbytes == 40 && !big_if.tx_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte40_fetch", {nbytes[7:0], big_if.tx_valid, big_busy}, {8'd40, 1'b0, 1'b1});
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("reset_abort", {big_if.tx_valid, big_busy, big_done, big_addr}, 13'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("reset_no_done", done_cnt, 0);
    check("reset_stays_idle", {big_if.tx_valid, big_busy}, 2'b00);

    // Restart after reset begins again at byte 0.
    start_frame();
    @(negedge clk);
    check("restart_addr0", {big_busy, big_addr}, {1'b1, 10'd0});
    wait_done(2000);
    end_checks("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
